// File: rtl/iir_coeff_loader_if.sv
// Coefficient word stream between the configuration path and the IIR coefficient loader.
// The master drives words with valid/last; the slave answers with ready.
interface iir_coeff_loader_if #(
    parameter int COEFF_WIDTH = 8
);
    logic [COEFF_WIDTH-1:0] in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/iir_coeff_loader.sv
// Collects b[0..M], a[0..M-1] into a shadow bank and swaps the whole set into the
// active bank in one cycle, so the filter never sees a half-written coefficient set.
module iir_coeff_loader #(
    parameter int M           = 2,
    parameter int COEFF_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    iir_coeff_loader_if.slave            in_if,
    input  logic                         abort,
    output logic [COEFF_WIDTH*(M+1)-1:0] packed_b_coeffs,
    output logic [COEFF_WIDTH*M-1:0]     packed_a_coeffs,
    output logic                         coeff_updated,
    output logic                         load_error,
    output logic                         busy
);
    localparam int N     = M + 1;
    localparam int K     = 2 * M + 1;
    localparam int CNT_W = $clog2(K);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(K - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [COEFF_WIDTH-1:0] shadow_q [K];
    logic [COEFF_WIDTH-1:0] shadow_d [K];
    logic [COEFF_WIDTH-1:0] active_q [K];
    logic [COEFF_WIDTH-1:0] active_d [K];
    logic                   coeff_updated_q, coeff_updated_d;
    logic                   load_error_q, load_error_d;

    logic ready;
    logic accept;

    // Ready is held low during reset and for the single commit cycle.
    assign ready          = rst_n && !abort && (state_q != ST_COMMIT);
    assign in_if.in_ready = ready;
    assign accept         = in_if.in_valid && ready;

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        shadow_d        = shadow_q;
        active_d        = active_q;
        coeff_updated_d = 1'b0;
        load_error_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_if.in_last) begin
                        load_error_d = 1'b1;
                        count_d      = '0;
                    end else begin
                        shadow_d[0] = in_if.in_data;
                        count_d     = CNT_W'(1);
                        state_d     = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (accept) begin
                    if (count_q == LAST_IDX) begin
                        if (in_if.in_last) begin
                            shadow_d[count_q] = in_if.in_data;
                            state_d           = ST_COMMIT;
                        end else begin
                            load_error_d = 1'b1;
                            state_d      = ST_IDLE;
                            count_d      = '0;
                        end
                    end else if (in_if.in_last) begin
                        load_error_d = 1'b1;
                        state_d      = ST_IDLE;
                        count_d      = '0;
                    end else begin
                        shadow_d[count_q] = in_if.in_data;
                        count_d           = count_q + 1'b1;
                    end
                end
            end

            ST_COMMIT: begin
                // Abort is deliberately ignored here: the swap always completes.
                active_d        = shadow_q;
                coeff_updated_d = 1'b1;
                state_d         = ST_IDLE;
                count_d         = '0;
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            count_q         <= '0;
            coeff_updated_q <= 1'b0;
            load_error_q    <= 1'b0;
            for (int i = 0; i < K; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            coeff_updated_q <= coeff_updated_d;
            load_error_q    <= load_error_d;
            for (int i = 0; i < K; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign coeff_updated = coeff_updated_q;
    assign load_error    = load_error_q;
    assign busy          = (state_q != ST_IDLE);

    // Active slots 0..M are b, M+1..2M are a, matching the filter's unpacking.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack_b
            assign packed_b_coeffs[COEFF_WIDTH*gi +: COEFF_WIDTH] = active_q[gi];
        end
        for (genvar gi = 0; gi < M; gi++) begin : g_pack_a
            assign packed_a_coeffs[COEFF_WIDTH*gi +: COEFF_WIDTH] = active_q[N+gi];
        end
    endgenerate
endmodule
